// File: rtl/valid_ready_round_robin_arbiter.sv
// rtl/valid_ready_round_robin_arbiter.sv - round-robin valid-ready arbiter with registered output stage; VALID_READY_ARBITER_PACKET_LOCK_EN enables packet locking
module valid_ready_round_robin_arbiter #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int CHANNEL_WIDTH = $clog2(CHANNELS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS*WIDTH-1:0]    input_data,
    input  logic [CHANNELS-1:0]          input_last,
    input  logic [CHANNELS-1:0]          input_valid,
    output logic [CHANNELS-1:0]          input_ready,
    output logic [WIDTH-1:0]             output_data,
    output logic                         output_last,
    output logic [CHANNEL_WIDTH-1:0]     output_channel,
    output logic                         output_valid,
    input  logic                         output_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                     state;
    logic [CHANNEL_WIDTH-1:0]   owner;
    logic [CHANNEL_WIDTH-1:0]   pointer;
    logic [CHANNEL_WIDTH-1:0]   grant_index;
    logic [CHANNEL_WIDTH-1:0]   next_pointer;
    logic [CHANNELS-1:0]        grant;
    logic                       grant_found;
    logic                       slot_free;
    logic                       accept;
    logic                       advance_pointer;

    // While locked the owner keeps the grant even if it momentarily drops valid.
    always_comb begin : search
        int idx;
        idx         = 0;
        grant_index = '0;
        grant_found = 1'b0;
        if (state == LOCKED) begin
            grant_index = owner;
            grant_found = 1'b1;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = int'(pointer) + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!grant_found && input_valid[CHANNEL_WIDTH'(idx)]) begin
                    grant_found = 1'b1;
                    grant_index = CHANNEL_WIDTH'(idx);
                end
            end
        end
    end

    assign grant        = grant_found ? (CHANNELS'(1) << grant_index) : '0;
    assign slot_free    = ~output_valid | output_ready;
    assign input_ready  = (reset | ~slot_free) ? '0 : grant;
    assign accept       = |(input_valid & input_ready);
    assign next_pointer = (grant_index == CHANNEL_WIDTH'(CHANNELS - 1)) ? '0
                                                                       : grant_index + CHANNEL_WIDTH'(1);

`ifdef VALID_READY_ARBITER_PACKET_LOCK_EN
    // Pointer moves only when a packet completes, so the next packet rotates.
    assign advance_pointer = accept & input_last[grant_index];
`else
    assign advance_pointer = accept;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            output_valid   <= 1'b0;
            output_data    <= '0;
            output_last    <= 1'b0;
            output_channel <= '0;
            pointer        <= '0;
            state          <= IDLE;
            owner          <= '0;
        end else begin
            if (accept) begin
                output_valid   <= 1'b1;
                output_data    <= input_data[grant_index*WIDTH +: WIDTH];
                output_last    <= input_last[grant_index];
                output_channel <= grant_index;
            end else if (output_ready) begin
                output_valid   <= 1'b0;
            end

            if (advance_pointer) pointer <= next_pointer;

`ifdef VALID_READY_ARBITER_PACKET_LOCK_EN
            if (accept) begin
                if (state == IDLE && !input_last[grant_index]) begin
                    state <= LOCKED;
                    owner <= grant_index;
                end else if (state == LOCKED && input_last[grant_index]) begin
                    state <= IDLE;
                end
            end
`else
            state <= IDLE;
            owner <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_valid_ready_round_robin_arbiter.sv
// tb/tb_valid_ready_round_robin_arbiter.sv - directed self-checking bench for valid_ready_round_robin_arbiter
module tb_valid_ready_round_robin_arbiter;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [CHANNELS*WIDTH-1:0]  input_data;
    logic [CHANNELS-1:0]        input_last;
    logic [CHANNELS-1:0]        input_valid;
    logic [CHANNELS-1:0]        input_ready;
    logic [WIDTH-1:0]           output_data;
    logic                       output_last;
    logic [1:0]                 output_channel;
    logic                       output_valid;
    logic                       output_ready;

    int checks = 0;
    int errors = 0;

    valid_ready_round_robin_arbiter #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .input_data     (input_data),
        .input_last     (input_last),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .output_data    (output_data),
        .output_last    (output_last),
        .output_channel (output_channel),
        .output_valid   (output_valid),
        .output_ready   (output_ready)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [7:0] d);
        input_data[ch*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset;
        reset        = 1'b1;
        input_valid  = '0;
        input_last   = '1;
        input_data   = '0;
        output_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        input_valid  = '1;
        input_last   = '1;
        input_data   = 32'h44332211;
        output_ready = 1'b1;
        tick();
        checks++;
        if (output_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b expected 0", output_valid);
        end
        checks++;
        if (output_channel !== 2'd0) begin
            errors++; $display("FAIL reset_channel: got %0d expected 0", output_channel);
        end
        checks++;
        if (output_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %0h expected 0", output_data);
        end
        checks++;
        if (input_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b expected 0000", input_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_fairness;
        int exp_ch[6] = '{0, 1, 2, 3, 0, 1};
        logic [7:0] exp_data;
        do_reset();
        input_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        input_last  = '1;
        input_valid = '1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_data = 8'h10 + 8'(exp_ch[i]);
            checks++;
            if (output_valid !== 1'b1 || output_channel !== 2'(exp_ch[i])) begin
                errors++;
                $display("FAIL fair_channel[%0d]: got valid %0b ch %0d expected valid 1 ch %0d",
                         i, output_valid, output_channel, exp_ch[i]);
            end
            checks++;
            if (output_data !== exp_data) begin
                errors++; $display("FAIL fair_data[%0d]: got %0h expected %0h", i, output_data, exp_data);
            end
        end
    endtask

    task automatic test_drain;
        input_valid = '0;
        #1;
        checks++;
        if (input_ready !== 4'b0000) begin
            errors++; $display("FAIL drain_ready: got %b expected 0000", input_ready);
        end
        tick();
        checks++;
        if (output_valid !== 1'b0) begin
            errors++; $display("FAIL drain_valid: got %0b expected 0", output_valid);
        end
        checks++;
        if (output_channel !== 2'd1 || output_data !== 8'h11) begin
            errors++;
            $display("FAIL drain_hold: got ch %0d data %0h expected ch 1 data 11", output_channel, output_data);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        input_valid = 4'b0100;
        set_data(2, 8'hA5);
        tick();
        checks++;
        if (output_valid !== 1'b1 || output_data !== 8'hA5 || output_channel !== 2'd2) begin
            errors++;
            $display("FAIL bp_load: got v %0b data %0h ch %0d expected v 1 data a5 ch 2",
                     output_valid, output_data, output_channel);
        end
        output_ready = 1'b0;
        input_valid  = 4'b0101;
        set_data(0, 8'h3C);
        set_data(2, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (input_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, input_ready);
            end
            tick();
            checks++;
            if (output_valid !== 1'b1 || output_data !== 8'hA5 || output_channel !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v %0b data %0h ch %0d expected v 1 data a5 ch 2",
                         i, output_valid, output_data, output_channel);
            end
        end
        output_ready = 1'b1;
        #1;
        checks++;
        if (input_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 0001", input_ready);
        end
        tick();
        checks++;
        if (output_valid !== 1'b1 || output_data !== 8'h3C || output_channel !== 2'd0) begin
            errors++;
            $display("FAIL bp_release_beat: got v %0b data %0h ch %0d expected v 1 data 3c ch 0",
                     output_valid, output_data, output_channel);
        end
    endtask

    task automatic test_sparse_wrap;
        int exp_ch[4] = '{3, 1, 3, 1};
        do_reset();
        input_valid = 4'b0010;
        set_data(1, 8'h21);
        tick();
        checks++;
        if (output_channel !== 2'd1 || output_data !== 8'h21) begin
            errors++;
            $display("FAIL sparse_setup: got ch %0d data %0h expected ch 1 data 21", output_channel, output_data);
        end
        input_valid = 4'b1010;
        set_data(3, 8'h43);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (output_valid !== 1'b1 || output_channel !== 2'(exp_ch[i])) begin
                errors++;
                $display("FAIL sparse_channel[%0d]: got v %0b ch %0d expected v 1 ch %0d",
                         i, output_valid, output_channel, exp_ch[i]);
            end
        end
    endtask

    task automatic test_packet_lock;
        int exp_ch[4];
        int ch1_sent;
        int got;
        logic [CHANNELS-1:0] rdy;
`ifdef VALID_READY_ARBITER_PACKET_LOCK_EN
        exp_ch = '{1, 1, 1, 0};
`else
        exp_ch = '{1, 0, 1, 0};
`endif
        do_reset();
        input_valid = 4'b0001;
        set_data(0, 8'h0F);
        tick();
        ch1_sent = 0;
        got      = 0;
        for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
            input_valid   = {2'b00, (ch1_sent < 3), 1'b1};
            input_last    = {2'b11, (ch1_sent == 2), 1'b1};
            set_data(1, 8'h50 + 8'(ch1_sent));
            #1;
            rdy = input_ready;
            tick();
            if (rdy[1] && input_valid[1]) ch1_sent++;
            if (output_valid) begin
                checks++;
                if (output_channel !== 2'(exp_ch[got])) begin
                    errors++;
                    $display("FAIL lock_channel[%0d]: got %0d expected %0d", got, output_channel, exp_ch[got]);
                end
                got++;
            end
        end
        if (got < 4) begin
            checks++;
            errors++;
            $display("FAIL lock_timeout: got %0d beats expected 4", got);
        end
        input_last = '1;
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        input_valid = 4'b1000;
        input_last  = 4'b0111;
        set_data(3, 8'h71);
        tick();
        set_data(3, 8'h72);
        tick();
        checks++;
        if (output_valid !== 1'b1 || output_data !== 8'h72 || output_channel !== 2'd3) begin
            errors++;
            $display("FAIL mid_beat2: got v %0b data %0h ch %0d expected v 1 data 72 ch 3",
                     output_valid, output_data, output_channel);
        end
        reset       = 1'b1;
        input_valid = 4'b1010;
        set_data(1, 8'h19);
        set_data(3, 8'h73);
        #1;
        checks++;
        if (input_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_ready: got %b expected 0000", input_ready);
        end
        tick();
        checks++;
        if (output_valid !== 1'b0) begin
            errors++; $display("FAIL mid_discard: got %0b expected 0", output_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (input_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_restart_ready: got %b expected 0010", input_ready);
        end
        tick();
        checks++;
        if (output_valid !== 1'b1 || output_channel !== 2'd1 || output_data !== 8'h19) begin
            errors++;
            $display("FAIL mid_restart_beat: got v %0b ch %0d data %0h expected v 1 ch 1 data 19",
                     output_valid, output_channel, output_data);
        end
    endtask

    initial begin
        reset        = 1'b1;
        input_valid  = '0;
        input_last   = '1;
        input_data   = '0;
        output_ready = 1'b1;
        test_reset();
        test_fairness();
        test_drain();
        test_backpressure();
        test_sparse_wrap();
        test_packet_lock();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
